// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes, run-state codes
// and the NOP word presented to the decoder while not fetching.
package fetch_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'b000,
        PC_BEQ  = 3'b001,
        PC_BNE  = 3'b010,
        PC_JUMP = 3'b011,
        PC_HALT = 3'b100
    } pc_ctrl_e;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_instr_mem.sv
// Instruction store: DEPTH x 32 words, synchronous write port for program
// loading and an asynchronous read port so fetch has zero latency.
module instr_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, next-PC selection (seq/branch/
// jump/halt), range-checked fetch and the LOAD/RUN/HALT run-state machine.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    input  logic [2:0]               pc_control,
    input  logic                     alu_zero,
    output logic [31:0]              instruction,
    output logic [31:0]              pc,
    output logic [31:0]              pc_plus4,
    output logic                     running,
    output logic                     halted,
    output logic                     fault
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic signed [31:0] branch_off;
    logic [31:0]       branch_target;
    logic [31:0]       jump_target;
    logic [31:0]       next_pc;
    logic              take_branch;
    logic              halt_req;
    logic              out_of_range;

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_instr_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc[AW+1:2]),
        .rdata (mem_rdata)
    );

    assign pc_plus4      = pc + 32'd4;
    assign branch_off    = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign branch_target = pc_plus4 + $unsigned(branch_off);
    assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};

    always_comb begin
        take_branch = 1'b0;
        case (pc_control)
            PC_BEQ:  take_branch = alu_zero;
            PC_BNE:  take_branch = !alu_zero;
            default: take_branch = 1'b0;
        endcase

        // Reserved codes 101-111 fall through to sequential fetch.
        if (take_branch) begin
            next_pc = branch_target;
        end else if (pc_control == PC_JUMP) begin
            next_pc = jump_target;
        end else begin
            next_pc = pc_plus4;
        end

        halt_req     = (pc_control == PC_HALT);
        out_of_range = ({1'b0, next_pc} >= MEM_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (start) state_next = ST_RUN;
            ST_RUN:  if (halt_req || out_of_range) state_next = ST_HALT;
            ST_HALT: if (start) state_next = ST_RUN;
            default: state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        running     = (state == ST_RUN);
        halted      = (state == ST_HALT);
        mem_we      = prog_we && (state == ST_LOAD);
        instruction = running ? mem_rdata : NOP_WORD;
    end

    // A faulting fetch leaves pc on the last in-range address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: pc <= RESET_PC;
                ST_RUN: begin
                    if (!halt_req) begin
                        if (out_of_range) begin
                            fault <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        pc    <= RESET_PC;
                        fault <= 1'b0;
                    end
                end
                default: pc <= RESET_PC;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: loading, sequential fetch, branches,
// jump, halt/restart, range fault, write gating and mid-run reset.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [2:0]  pc_control;
    logic        alu_zero;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        running;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_pc_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc_control  (pc_control),
        .alu_zero    (alu_zero),
        .instruction (instruction),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .running     (running),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] addr, input logic [31:0] data, input logic st);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        start     = st;
        tick();
        prog_we   = 1'b0;
        start     = 1'b0;
    endtask

    // Halt, restart from RESET_PC, then step n sequential fetches.
    task automatic restart(input int n);
        pc_control = PC_HALT;
        alu_zero   = 1'b0;
        tick();
        pc_control = PC_SEQ;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", pc); else n_pass++;
        n_checks++; if (instruction !== 32'h0) $display("FAIL reset_instr: got %h expected 00000000", instruction); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (running !== 1'b0 || pc !== 32'h0) $display("FAIL load_idle: got running=%b pc=%h expected 0/00000000", running, pc); else n_pass++;
    endtask

    task automatic test_load_and_seq();
        write_word(8'd1,  32'h010A4020, 1'b0);
        for (int i = 2; i < 8; i++) write_word(8'(i), 32'h0000_0020, 1'b0);
        write_word(8'd4,  32'h1509FFFC, 1'b0);
        write_word(8'd8,  32'h11090048, 1'b0);
        write_word(8'd9,  32'h08000007, 1'b0);
        write_word(8'd10, 32'h080000FF, 1'b0);
        write_word(8'hFF, 32'h0000_0000, 1'b0);
        n_checks++; if (running !== 1'b0) $display("FAIL load_no_run: got %b expected 0", running); else n_pass++;
        // Final word written on the same edge as start.
        pc_control = PC_SEQ;
        write_word(8'd0, 32'h21080002, 1'b1);
        n_checks++; if (running !== 1'b1) $display("FAIL run_entry: got %b expected 1", running); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL seq_pc0: got %h expected 00000000", pc); else n_pass++;
        n_checks++; if (instruction !== 32'h21080002) $display("FAIL seq_instr0: got %h expected 21080002", instruction); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h4) $display("FAIL seq_pc1: got %h expected 00000004", pc); else n_pass++;
        n_checks++; if (instruction !== 32'h010A4020) $display("FAIL seq_instr1: got %h expected 010a4020", instruction); else n_pass++;
        n_checks++; if (pc_plus4 !== 32'h8) $display("FAIL seq_pc_plus4: got %h expected 00000008", pc_plus4); else n_pass++;
    endtask

    task automatic test_beq();
        restart(8);
        n_checks++; if (pc !== 32'h20 || instruction !== 32'h11090048) $display("FAIL beq_setup: got pc=%h instr=%h expected 00000020/11090048", pc, instruction); else n_pass++;
        pc_control = PC_BEQ;
        alu_zero   = 1'b1;
        tick();
        n_checks++; if (pc !== 32'h144) $display("FAIL beq_taken: got %h expected 00000144", pc); else n_pass++;
        n_checks++; if (running !== 1'b1 || fault !== 1'b0) $display("FAIL beq_state: got running=%b fault=%b expected 1/0", running, fault); else n_pass++;
        restart(8);
        pc_control = PC_BEQ;
        alu_zero   = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h24) $display("FAIL beq_not_taken: got %h expected 00000024", pc); else n_pass++;
    endtask

    task automatic test_bne();
        restart(4);
        pc_control = PC_BNE;
        alu_zero   = 1'b1;
        tick();
        n_checks++; if (pc !== 32'h14) $display("FAIL bne_not_taken: got %h expected 00000014", pc); else n_pass++;
        restart(4);
        n_checks++; if (instruction !== 32'h1509FFFC) $display("FAIL bne_setup: got %h expected 1509fffc", instruction); else n_pass++;
        pc_control = PC_BNE;
        alu_zero   = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h4) $display("FAIL bne_neg_offset: got %h expected 00000004", pc); else n_pass++;
    endtask

    task automatic test_jump();
        restart(9);
        pc_control = PC_JUMP;
        tick();
        n_checks++; if (pc !== 32'h1C) $display("FAIL jump_target: got %h expected 0000001c", pc); else n_pass++;
    endtask

    task automatic test_halt();
        pc_control = PC_HALT;
        tick();
        n_checks++; if (halted !== 1'b1 || running !== 1'b0) $display("FAIL halt_state: got halted=%b running=%b expected 1/0", halted, running); else n_pass++;
        n_checks++; if (pc !== 32'h1C) $display("FAIL halt_pc: got %h expected 0000001c", pc); else n_pass++;
        n_checks++; if (instruction !== 32'h0) $display("FAIL halt_instr: got %h expected 00000000", instruction); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL halt_fault: got %b expected 0", fault); else n_pass++;
        pc_control = PC_SEQ;
        tick();
        n_checks++; if (pc !== 32'h1C || halted !== 1'b1) $display("FAIL halt_frozen: got pc=%h halted=%b expected 0000001c/1", pc, halted); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (pc !== 32'h0 || running !== 1'b1 || halted !== 1'b0) $display("FAIL restart: got pc=%h running=%b halted=%b expected 00000000/1/0", pc, running, halted); else n_pass++;
    endtask

    task automatic test_fault();
        restart(10);
        pc_control = PC_JUMP;
        tick();
        n_checks++; if (pc !== 32'h3FC) $display("FAIL fault_setup: got %h expected 000003fc", pc); else n_pass++;
        pc_control = PC_SEQ;
        tick();
        n_checks++; if (halted !== 1'b1 || fault !== 1'b1) $display("FAIL fault_flag: got halted=%b fault=%b expected 1/1", halted, fault); else n_pass++;
        n_checks++; if (pc !== 32'h3FC) $display("FAIL fault_pc: got %h expected 000003fc", pc); else n_pass++;
        tick();
        n_checks++; if (fault !== 1'b1) $display("FAIL fault_sticky: got %b expected 1", fault); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (fault !== 1'b0 || pc !== 32'h0 || running !== 1'b1) $display("FAIL fault_clear: got fault=%b pc=%h running=%b expected 0/00000000/1", fault, pc, running); else n_pass++;
    endtask

    task automatic test_gating();
        prog_we    = 1'b1;
        prog_addr  = 8'd0;
        prog_data  = 32'hDEADBEEF;
        pc_control = 3'b111;
        start      = 1'b1;
        tick();
        prog_we    = 1'b0;
        start      = 1'b0;
        n_checks++; if (pc !== 32'h4 || running !== 1'b1) $display("FAIL reserved_ctrl_seq: got pc=%h running=%b expected 00000004/1", pc, running); else n_pass++;
        restart(0);
        n_checks++; if (instruction !== 32'h21080002) $display("FAIL run_write_gated: got %h expected 21080002", instruction); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        restart(2);
        n_checks++; if (pc !== 32'h8) $display("FAIL midrun_setup: got %h expected 00000008", pc); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if (running !== 1'b0 || halted !== 1'b0) $display("FAIL midrun_state: got running=%b halted=%b expected 0/0", running, halted); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL midrun_pc: got %h expected 00000000", pc); else n_pass++;
        n_checks++; if (instruction !== 32'h0) $display("FAIL midrun_instr: got %h expected 00000000", instruction); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        pc_control = PC_SEQ;
        alu_zero   = 1'b0;
        test_reset();
        test_load_and_seq();
        test_beq();
        test_bne();
        test_jump();
        test_halt();
        test_fault();
        test_gating();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
